// File: rtl/regfile_multiport_if.sv
// Port bundle for regfile_multiport: one write port, NRD read ports and the clear-sweep controls.
// Port semantics: this bundle has no valid/ready backpressure.
//   - regwrite qualifies adr_rd/din_rd at each rising clock edge, and a write
//     is never stalled.
//   - adr_rs -> dout_rs is a zero-latency combinational read.
//   - A one-cycle init_req pulse starts a clear sweep.
//   - init_busy is high while the sweep runs; writes are dropped during that time.
interface regfile_multiport_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                regwrite;
    logic [AW-1:0]       adr_rd;
    logic [XLEN-1:0]     din_rd;
    logic [NRD*AW-1:0]   adr_rs;
    logic [NRD*XLEN-1:0] dout_rs;
    logic                init_req;
    logic                init_busy;

    modport master (
        output regwrite, adr_rd, din_rd, adr_rs, init_req,
        input  dout_rs, init_busy
    );

    modport slave (
        input  regwrite, adr_rd, din_rd, adr_rs, init_req,
        output dout_rs, init_busy
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multiport integer register file with a synchronous write port and combinational reads.
// Includes an optional write-to-read bypass, an optional hardwired-zero x0, and
// a clear sequencer that zeroes every entry after reset or when init_req is pulsed.
module regfile_multiport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1,
    parameter bit ZERO0  = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_multiport_if.slave bus,
    output logic              dbg_state,    // 0 = CLEAR, 1 = IDLE
    output logic [AW-1:0]     dbg_clr_ptr
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_ptr_q, clr_ptr_d;
    logic [XLEN-1:0]     mem_q [NREGS];

    logic                mem_we_d;
    logic [AW-1:0]       mem_wa_d;
    logic [XLEN-1:0]     mem_wd_d;
    logic                wr_x0;
    logic                wr_ok;
    logic [AW-1:0]       ra;
    logic [NRD*XLEN-1:0] dout_c;

    // A write aimed at x0 is discarded when x0 is hardwired to zero.
    assign wr_x0 = ZERO0 && (bus.adr_rd == '0);
    assign wr_ok = bus.regwrite && !wr_x0;

    // State and sweep pointer; reset always restarts the sweep at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state and single array write port. The sweep owns the write port in CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we_d  = 1'b0;
        mem_wa_d  = bus.adr_rd;
        mem_wd_d  = bus.din_rd;
        case (state_q)
            ST_CLEAR: begin
                mem_we_d  = 1'b1;
                mem_wa_d  = clr_ptr_q;
                mem_wd_d  = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == AW'(NREGS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A write in the same cycle as init_req still commits.
                mem_we_d = wr_ok;
                if (bus.init_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage array: no reset here, because the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_wa_d] <= mem_wd_d;
        end
    end

    // Read ports: all ports return zero during the sweep. Otherwise the
    // priority is x0 forced to zero, then the bypass path, then the array.
    always_comb begin
        dout_c = '0;
        ra     = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.adr_rs[k*AW +: AW];
            if (state_q == ST_CLEAR) begin
                dout_c[k*XLEN +: XLEN] = '0;
            end else if (ZERO0 && (ra == '0)) begin
                dout_c[k*XLEN +: XLEN] = '0;
            end else if (BYPASS && wr_ok && (bus.adr_rd == ra)) begin
                dout_c[k*XLEN +: XLEN] = bus.din_rd;
            end else begin
                dout_c[k*XLEN +: XLEN] = mem_q[ra];
            end
        end
    end

    assign bus.dout_rs   = dout_c;
    assign bus.init_busy = (state_q == ST_CLEAR);
    assign dbg_state     = state_q;
    assign dbg_clr_ptr   = clr_ptr_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport with two instances.
// u_dut2 uses NRD=2, BYPASS=1, ZERO0=1. u_dut3 uses NRD=3, BYPASS=0, ZERO0=1.
module tb_regfile_multiport;

    logic clk;
    logic rst_n;

    logic       dbg2_state, dbg3_state;
    logic [4:0] dbg2_ptr, dbg3_ptr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus2 ();
    regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(3)) bus3 ();

    regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1), .ZERO0(1'b1)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .dbg_state   (dbg2_state),
        .dbg_clr_ptr (dbg2_ptr)
    );

    regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1'b0), .ZERO0(1'b1)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus3),
        .dbg_state   (dbg3_state),
        .dbg_clr_ptr (dbg3_ptr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string name, input logic [31:0] act);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h but the expected queue is empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
        push_exp(e);
        check_pop(name, act);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drivers
    task automatic idle_inputs();
        bus2.regwrite = 1'b0; bus2.adr_rd = '0; bus2.din_rd = '0;
        bus2.adr_rs = '0; bus2.init_req = 1'b0;
        bus3.regwrite = 1'b0; bus3.adr_rd = '0; bus3.din_rd = '0;
        bus3.adr_rs = '0; bus3.init_req = 1'b0;
    endtask

    // Watch a sweep cycle by cycle and count the busy cycles into cnt.
    // In cycle write_at, a write of x3 is attempted. In cycle req_at, init_req is pulsed.
    // The task returns early, mid-sweep, once stop_at busy cycles have been seen.
    task automatic sweep_watch(input int write_at, input int req_at, input int stop_at,
                               input bit chk3, output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            bus2.regwrite = (i == write_at);
            bus2.adr_rd   = 5'd3;
            bus2.din_rd   = 32'h0000ABCD;
            bus2.init_req = (i == req_at);
            bus2.adr_rs   = {5'($urandom_range(1, 31)), 5'd3};
            bus3.regwrite = chk3 && (i == write_at);
            bus3.adr_rd   = 5'd3;
            bus3.din_rd   = 32'h0000ABCD;
            bus3.adr_rs   = {5'd3, 5'($urandom_range(1, 31)), 5'd5};
            #2;
            if (!bus2.init_busy) break;
            cnt++;
            push_exp(32'h0); check_pop("sweep_rd2_p0", bus2.dout_rs[31:0]);
            push_exp(32'h0); check_pop("sweep_rd2_p1", bus2.dout_rs[63:32]);
            if (chk3) begin
                check_val("sweep_busy3", {31'h0, bus3.init_busy}, 32'h1);
                for (int k = 0; k < 3; k++) begin
                    push_exp(32'h0);
                    check_pop("sweep_rd3", bus3.dout_rs[k*32 +: 32]);
                end
            end
            if (cnt == stop_at) return;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cnt;

        // One cycle per row: read results are sampled in the same cycle, and the write commits at the following edge.
        vecs[0] = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd2,  32'hFFFFFFFF, 32'h00000000};
        vecs[1] = '{1'b0, 5'd1,  32'h00000000, 5'd1,  5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
        vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd1,  32'h00000000, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd2,  32'hFFFF0000, 5'd2,  5'd1,  32'hFFFF0000, 32'hFFFFFFFF};
        vecs[5] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd2,  32'hDEADBEEF, 32'hFFFF0000};
        vecs[6] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 5'd1,  32'h55555555, 5'd1,  5'd0,  32'h00000001, 32'h00000000};
        vecs[8] = '{1'b0, 5'd0,  32'h00000000, 5'd2,  5'd31, 32'hFFFF0000, 32'hDEADBEEF};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check_val("rst_busy2", {31'h0, bus2.init_busy}, 32'h1);
        check_val("rst_state2", {31'h0, dbg2_state}, 32'h0);
        check_val("rst_ptr2", {27'h0, dbg2_ptr}, 32'h0);
        check_val("rst_busy3", {31'h0, bus3.init_busy}, 32'h1);
        check_val("rst_rd2_p0", bus2.dout_rs[31:0], 32'h0);
        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;

        // Initial sweep after reset release: busy for exactly 32 clocks, with all reads returning 0
        sweep_watch(-1, -1, -1, 1'b1, cnt);
        check_val("init_sweep_len", 32'(cnt), 32'd32);
        check_val("init_idle3", {31'h0, bus3.init_busy}, 32'h0);

        // All entries read back as 0 after the sweep
        for (int a = 0; a < 32; a++) begin
            bus2.adr_rs = {5'(31 - a), 5'(a)};
            bus3.adr_rs = {5'(a), 5'(a), 5'(a)};
            push_exp(32'h0); push_exp(32'h0);
            #2;
            check_pop("post_clr_p0", bus2.dout_rs[31:0]);
            check_pop("post_clr_p1", bus2.dout_rs[63:32]);
            check_val("post_clr3_p2", bus3.dout_rs[95:64], 32'h0);
            next_cycle();
        end

        // Table vectors on u_dut2: bypass, x0 handling and plain writes
        for (int v = 0; v < 9; v++) begin
            bus2.regwrite = vecs[v].we;
            bus2.adr_rd   = vecs[v].wa;
            bus2.din_rd   = vecs[v].wd;
            bus2.adr_rs   = {vecs[v].ra1, vecs[v].ra0};
            push_exp(vecs[v].e0);
            push_exp(vecs[v].e1);
            #2;
            check_pop("vec_p0", bus2.dout_rs[31:0]);
            check_pop("vec_p1", bus2.dout_rs[63:32]);
            next_cycle();
        end
        idle_inputs();

        // init_req together with a write: the write still commits and is visible through the bypass
        bus2.init_req = 1'b1;
        bus2.regwrite = 1'b1;
        bus2.adr_rd   = 5'd3;
        bus2.din_rd   = 32'h11111111;
        bus2.adr_rs   = {5'd2, 5'd3};
        #2;
        check_val("req_byp_p0", bus2.dout_rs[31:0], 32'h11111111);
        check_val("req_old_p1", bus2.dout_rs[63:32], 32'hFFFF0000);
        check_val("req_not_busy_yet", {31'h0, bus2.init_busy}, 32'h0);
        next_cycle();
        idle_inputs();

        // Requested sweep: a write in cycle 7 is dropped and init_req in cycle 12 is ignored
        sweep_watch(7, 12, -1, 1'b0, cnt);
        check_val("req_sweep_len", 32'(cnt), 32'd32);
        bus2.adr_rs = {5'd3, 5'd2};
        #2;
        check_val("after_req_x2", bus2.dout_rs[31:0], 32'h0);
        check_val("after_req_x3", bus2.dout_rs[63:32], 32'h0);
        next_cycle();
        bus2.adr_rs = {5'd31, 5'd1};
        #2;
        check_val("after_req_x1", bus2.dout_rs[31:0], 32'h0);
        check_val("after_req_x31", bus2.dout_rs[63:32], 32'h0);
        next_cycle();

        // Reset asserted at sweep cycle 10 restarts the sweep from 0
        bus2.init_req = 1'b1;
        next_cycle();
        bus2.init_req = 1'b0;
        sweep_watch(-1, -1, 10, 1'b0, cnt);
        check_val("pre_abort_cnt", 32'(cnt), 32'd10);
        check_val("pre_abort_ptr", {27'h0, dbg2_ptr}, 32'd9);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", {31'h0, bus2.init_busy}, 32'h1);
        check_val("abort_ptr", {27'h0, dbg2_ptr}, 32'h0);
        next_cycle();
        check_val("abort_hold_ptr", {27'h0, dbg2_ptr}, 32'h0);
        rst_n = 1'b1;
        sweep_watch(-1, -1, -1, 1'b1, cnt);
        check_val("restart_sweep_len", 32'(cnt), 32'd32);

        // u_dut3 without bypass: the cycle of the write returns the old value, and the new value appears one cycle later
        bus3.regwrite = 1'b1;
        bus3.adr_rd   = 5'd5;
        bus3.din_rd   = 32'h11111111;
        next_cycle();
        bus3.din_rd   = 32'hA5A5A5A5;
        bus3.adr_rs   = {5'd5, 5'd5, 5'd5};
        for (int k = 0; k < 3; k++) push_exp(32'h11111111);
        #2;
        for (int k = 0; k < 3; k++) check_pop("nobyp_old", bus3.dout_rs[k*32 +: 32]);
        next_cycle();
        bus3.regwrite = 1'b0;
        for (int k = 0; k < 3; k++) push_exp(32'hA5A5A5A5);
        #2;
        for (int k = 0; k < 3; k++) check_pop("nobyp_new", bus3.dout_rs[k*32 +: 32]);
        next_cycle();

        // x0 on u_dut3 ignores writes
        bus3.regwrite = 1'b1;
        bus3.adr_rd   = 5'd0;
        bus3.din_rd   = 32'hCAFEF00D;
        bus3.adr_rs   = {5'd0, 5'd5, 5'd0};
        #2;
        check_val("x0_wr3_p0", bus3.dout_rs[31:0], 32'h0);
        next_cycle();
        bus3.regwrite = 1'b0;
        #2;
        check_val("x0_after3_p2", bus3.dout_rs[95:64], 32'h0);
        check_val("x5_keep3_p1", bus3.dout_rs[63:32], 32'hA5A5A5A5);
        next_cycle();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
